// File: rtl/bpc_pkg.sv
// Shared constants and types for the ZRL bit packer and its neighbouring stages.
package bpc_pkg;

  localparam int BPC_W_IN   = 68;
  localparam int BPC_W_OUT  = 64;
  localparam int BPC_SIZE_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2
  } bpc_state_e;

  // ZRL codeword header codes, common with the encoder
  localparam logic [1:0] ZRL_HDR_ZRUN = 2'b00;
  localparam logic [1:0] ZRL_HDR_LIT  = 2'b01;
  localparam logic [1:0] ZRL_HDR_ESC  = 2'b10;
  localparam logic [1:0] ZRL_HDR_RAW  = 2'b11;

endpackage

// File: rtl/bpc_out_reg.sv
// Valid/ready holding register for one packed word, its valid-bit count and framing flags.
module bpc_out_reg
  import bpc_pkg::*;
#(
  parameter int W   = BPC_W_OUT,
  parameter int LBW = BPC_SIZE_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [W-1:0]   word,
  input  logic [LBW-1:0] word_bits,
  input  logic           word_sop,
  input  logic           word_eop,
  input  logic           ready,
  output logic           free,
  output logic [W-1:0]   data,
  output logic [LBW-1:0] last_bits,
  output logic           sop,
  output logic           eop,
  output logic           valid
);

  assign free = !valid | ready;

  // load is only raised while free, so a stalled word is never overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= '0;
      last_bits <= '0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      valid     <= 1'b0;
    end else if (load) begin
      data      <= word;
      last_bits <= word_bits;
      sop       <= word_sop;
      eop       <= word_eop;
      valid     <= 1'b1;
    end else if (ready) begin
      valid     <= 1'b0;
    end
  end

endmodule

// File: rtl/bpc_bit_packer.sv
// Packs MSB-aligned variable-length ZRL codewords into a gapless stream of 64-bit words.
//   state    | meaning
//   ST_IDLE  | no open packet, accumulator empty
//   ST_FILL  | packet open, appending codewords
//   ST_FLUSH | eop accepted, draining remaining bits; input blocked
module bpc_bit_packer
  import bpc_pkg::*;
#(
  parameter int W_IN  = BPC_W_IN,
  parameter int W_OUT = BPC_W_OUT,
  parameter int ACC_W = W_IN + W_OUT,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W_IN-1:0]       data_i,
  input  logic [BPC_SIZE_W-1:0] size_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [W_OUT-1:0]      data_o,
  output logic [BPC_SIZE_W-1:0] last_bits_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam logic [CNT_W-1:0]      WORD_CNT  = CNT_W'(W_OUT);
  localparam logic [BPC_SIZE_W-1:0] WORD_BITS = BPC_SIZE_W'(W_OUT);
  localparam logic [BPC_SIZE_W-1:0] MAX_SIZE  = BPC_SIZE_W'(W_IN);
  localparam logic [ACC_W-1:0]      ACC_ONES  = '1;

  bpc_state_e state, state_next;

  logic [ACC_W-1:0]      acc, acc_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  sop_pend, sop_pend_next;
  logic                  out_free, pop, accept, eop_pop;
  logic [BPC_SIZE_W-1:0] take_bits;
  logic [CNT_W-1:0]      popped, c1, size_eff;
  logic [ACC_W-1:0]      ins_mask, ins_bits;

  always_comb begin
    size_eff  = (size_i > MAX_SIZE) ? CNT_W'(W_IN) : CNT_W'(size_i);
    take_bits = (cnt >= WORD_CNT) ? WORD_BITS : cnt[BPC_SIZE_W-1:0];
    // in FLUSH a pop happens even with cnt==0 so an empty packet still gets its eop word
    pop       = out_free & ((cnt >= WORD_CNT) | (state == ST_FLUSH));
    popped    = pop ? CNT_W'(take_bits) : '0;
    c1        = cnt - popped;
    eop_pop   = pop & (state == ST_FLUSH) & (c1 == '0);
    ready_o   = rst_n & (state != ST_FLUSH) & ((cnt <= WORD_CNT) | pop);
    accept    = valid_i & ready_o;
    ins_mask  = ~(ACC_ONES >> size_eff);
    ins_bits  = ({data_i, {W_OUT{1'b0}}} & ins_mask) >> c1;
    acc_next  = (acc << popped) | (accept ? ins_bits : '0);
    cnt_next  = c1 + (accept ? size_eff : '0);
  end

  always_comb begin
    state_next    = state;
    sop_pend_next = sop_pend;
    if (pop) sop_pend_next = 1'b0;
    if (accept & sop_i) sop_pend_next = 1'b1;
    case (state)
      ST_IDLE: begin
        if (accept & eop_i)      state_next = ST_FLUSH;
        else if (accept & sop_i) state_next = ST_FILL;
      end
      ST_FILL: begin
        if (accept & eop_i) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (eop_pop) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      acc      <= '0;
      cnt      <= '0;
      sop_pend <= 1'b0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      cnt      <= cnt_next;
      sop_pend <= sop_pend_next;
    end
  end

  bpc_out_reg #(
    .W   (W_OUT),
    .LBW (BPC_SIZE_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pop),
    .word      (acc[ACC_W-1 -: W_OUT]),
    .word_bits (take_bits),
    .word_sop  (sop_pend),
    .word_eop  (eop_pop),
    .ready     (ready_i),
    .free      (out_free),
    .data      (data_o),
    .last_bits (last_bits_o),
    .sop       (sop_o),
    .eop       (eop_o),
    .valid     (valid_o)
  );

  property p_size_legal;
    @(posedge clk) disable iff (!rst_n) valid_i |-> (size_i <= MAX_SIZE);
  endproperty
  a_size_legal: assert property (p_size_legal);

endmodule

// File: tb/tb_bpc_bit_packer.sv
// Scoreboard bench for bpc_bit_packer: directed packets, expected words queued at issue time.
module tb_bpc_bit_packer;
  import bpc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [67:0] data_i;
  logic [6:0]  size_i;
  logic        sop_i, eop_i, valid_i, ready_o;
  logic [63:0] data_o;
  logic [6:0]  last_bits_o;
  logic        sop_o, eop_o, valid_o, ready_i;

  bpc_bit_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_i      (data_i),
    .size_i      (size_i),
    .sop_i       (sop_i),
    .eop_i       (eop_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .last_bits_o (last_bits_o),
    .sop_o       (sop_o),
    .eop_o       (eop_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [6:0]  bits;
    logic        sop;
    logic        eop;
  } word_t;

  word_t       exp_q[$];
  logic [67:0] pkt_d[$];
  int          pkt_s[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          words_seen = 0;
  int          ready_waits = 0;
  word_t       last_word;
  word_t       got_w, want_w;

  task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic chki(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: every handshaken output word is checked against the head of the queue
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && valid_o && ready_i) begin
        got_w = '{data: data_o, bits: last_bits_o, sop: sop_o, eop: eop_o};
        last_word = got_w;
        words_seen++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got data=%h bits=%0d sop=%b eop=%b, none expected",
                   got_w.data, got_w.bits, got_w.sop, got_w.eop);
        end else begin
          want_w = exp_q.pop_front();
          if (got_w !== want_w) begin
            n_fail++;
            $display("FAIL word: got data=%h bits=%0d sop=%b eop=%b want data=%h bits=%0d sop=%b eop=%b",
                     got_w.data, got_w.bits, got_w.sop, got_w.eop,
                     want_w.data, want_w.bits, want_w.sop, want_w.eop);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [63:0] d, input int bits, input logic sop, input logic eop);
    word_t e;
    e.data = d;
    e.bits = 7'(bits);
    e.sop  = sop;
    e.eop  = eop;
    exp_q.push_back(e);
  endtask

  task automatic add_beat(input logic [67:0] d, input int s);
    pkt_d.push_back(d);
    pkt_s.push_back(s);
  endtask

  // Reference bitstream: concatenate codeword bits, cut into 64-bit words, pad the last
  task automatic expect_packet();
    logic        bq[$];
    logic [67:0] d;
    word_t       e;
    int          n, nw, rem;
    for (int b = 0; b < pkt_s.size(); b++) begin
      d = pkt_d[b];
      for (int i = 0; i < pkt_s[b]; i++) bq.push_back(d[67-i]);
    end
    n  = bq.size();
    nw = (n == 0) ? 1 : (n + 63) / 64;
    for (int w = 0; w < nw; w++) begin
      e.data = '0;
      for (int i = 0; i < 64; i++)
        if (w * 64 + i < n) e.data[63-i] = bq[w*64+i];
      rem    = n - w * 64;
      e.bits = 7'((rem >= 64) ? 64 : rem);
      e.sop  = (w == 0);
      e.eop  = (w == nw - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [67:0] d, input int s, input logic sop, input logic eop);
    int w;
    bit done;
    w = 0;
    done = 0;
    data_i  = d;
    size_i  = 7'(s);
    sop_i   = sop;
    eop_i   = eop;
    valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (ready_o) done = 1;
      else begin
        w++;
        if (w > 200) begin
          n_cmp++;
          n_fail++;
          $display("FAIL send_timeout: ready_o low for %0d cycles, required high within 200", w);
          done = 1;
        end
      end
    end
    ready_waits += w;
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet();
    for (int b = 0; b < pkt_s.size(); b++)
      send_beat(pkt_d[b], pkt_s[b], b == 0, b == pkt_s.size() - 1);
    valid_i = 1'b0;
    sop_i   = 1'b0;
    eop_i   = 1'b0;
    pkt_d.delete();
    pkt_s.delete();
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || valid_o) && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
    chki("drain_pending_words", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws, rw;
    rst_n = 1'b0; data_i = '0; size_i = '0; sop_i = 0; eop_i = 0; valid_i = 0; ready_i = 1;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_valid_o", valid_o, 1'b0);
    chk64("rst_data_o", data_o, 64'h0);
    chki("rst_last_bits", int'(last_bits_o), 0);
    chk1("rst_sop_o", sop_o, 1'b0);
    chk1("rst_eop_o", eop_o, 1'b0);
    chk1("rst_ready_o", ready_o, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("ready_after_reset", ready_o, 1'b1);

    // Eight 8-bit literal codes (01_000000) fill exactly one word; eop rides on it
    for (int k = 0; k < 8; k++) add_beat({ZRL_HDR_LIT, 6'b000000, 60'h0}, 8);
    push_exp(64'h4040_4040_4040_4040, 64, 1'b1, 1'b1);
    send_packet();
    wait_drain();

    // Size-0 one-beat packet: a single empty eop word
    add_beat(68'h0, 0);
    push_exp(64'h0, 0, 1'b1, 1'b1);
    send_packet();
    wait_drain();

    // One 68-bit beat: spills 4 bits into a padded second word; check t+2 latency
    push_exp(64'h7FFF_FFFF_FFFF_FFFF, 64, 1'b1, 1'b0);
    push_exp(64'hF000_0000_0000_0000, 4, 1'b0, 1'b1);
    send_beat({ZRL_HDR_LIT, ZRL_HDR_RAW, 64'hFFFF_FFFF_FFFF_FFFF}, 68, 1'b1, 1'b1);
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    chk1("latency_t1_valid", valid_o, 1'b0);
    @(posedge clk);
    #1;
    chk1("latency_t2_valid", valid_o, 1'b1);
    wait_drain();

    // 30 continuous 22-bit beats: 660 bits -> 10 full words + 20-bit tail
    ws = words_seen;
    ready_waits = 0;
    for (int k = 0; k < 30; k++) add_beat({22'(k * 32'h1357B + 32'h2A5), 46'h0}, 22);
    expect_packet();
    send_packet();
    wait_drain();
    chki("stream_word_count", words_seen - ws, 11);
    chki("stream_ready_stalls", ready_waits, 0);
    chki("stream_tail_bits", int'(last_word.bits), 20);
    chk1("stream_tail_eop", last_word.eop, 1'b1);

    // 68-bit beats into a stalled output: ready_o must drop, held word must not change
    add_beat(68'hA_0123_4567_89AB_CDEF, 68);
    add_beat(68'h5_FEDC_BA98_7654_3210, 68);
    add_beat(68'h3_C3C3_C3C3_C3C3_C3C3, 68);
    add_beat(68'h9_0F0F_1E1E_2D2D_3C3C, 68);
    add_beat(68'h6_DEAD_BEEF_CAFE_F00D, 68);
    expect_packet();
    fork
      send_packet();
      begin
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("stall_ready_o_low", ready_o, 1'b0);
        chk1("stall_valid_o", valid_o, 1'b1);
        chk64("stall_data_early", data_o, 64'hA012_3456_789A_BCDE);
        repeat (3) @(posedge clk);
        #1;
        chk1("stall_ready_o_still_low", ready_o, 1'b0);
        chk64("stall_data_late", data_o, 64'hA012_3456_789A_BCDE);
        chk1("stall_sop_late", sop_o, 1'b1);
        ready_i = 1'b1;
      end
    join
    wait_drain();

    // eop then an immediate sop: new packet waits out the two-word flush
    add_beat(68'hAB_CDEF_0123 << 28, 40);
    add_beat(68'h45_6789_ABCD << 28, 40);
    push_exp(64'hABCD_EF01_2345_6789, 64, 1'b1, 1'b0);
    push_exp(64'hABCD_0000_0000_0000, 16, 1'b0, 1'b1);
    push_exp(64'hFFC0_0000_0000_0000, 10, 1'b1, 1'b1);
    send_packet();
    chk1("flush_blocks_ready", ready_o, 1'b0);
    rw = ready_waits;
    send_beat(68'h3FF << 58, 10, 1'b1, 1'b1);
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    chki("sop_after_eop_wait_cycles", ready_waits - rw, 2);
    wait_drain();

    // Reset while in FLUSH with 40 bits buffered and the first word stalled
    ready_i = 1'b0;
    add_beat(68'h8_1234_5678_9ABC_DEF0, 68);
    add_beat(68'hF_FFFF_FFFF << 32, 36);
    send_packet();
    chk1("pre_rst_ready_o", ready_o, 1'b0);
    chk1("pre_rst_valid_o", valid_o, 1'b1);
    chk64("pre_rst_data_o", data_o, 64'h8123_4567_89AB_CDEF);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("midrst_valid_o", valid_o, 1'b0);
    chk64("midrst_data_o", data_o, 64'h0);
    chki("midrst_last_bits", int'(last_bits_o), 0);
    chk1("midrst_sop_o", sop_o, 1'b0);
    chk1("midrst_ready_o", ready_o, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_i = 1'b1;
    push_exp(64'hB400_0000_0000_0000, 6, 1'b1, 1'b1);
    send_beat(68'h2D << 62, 6, 1'b1, 1'b1);
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
